seven_seg_scanner: RTL

Display-side consumer of the 10 kHz scan clock produced by `clock_divider_7seg`. It converts the Game of Life iteration count to four BCD digits with a sequential double-dabble, holds them in a display register, and time-multiplexes them onto the board's active-low common-anode 7-segment display. One digit advances per rising edge of the scan clock. The scan clock is sampled in the 100 MHz domain; it is never used as a clock.

---
 rtl/seg_pkg.sv | 41 ++++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/seven_seg_scanner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared digit type, segment codes and BCD-to-segment decode for the scan display.
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   function automatic logic [6:0] seg_decode(input bcd_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: saturates the input to 9999, then one shift-add-3 per clk.
// busy is high for BIN_WIDTH cycles; done pulses with the final digits.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int BIN_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  bin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output bcd_t [NUM_DIGITS-1:0] bcd
);

   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

   logic                 run_r;
   logic                 busy_r;
   logic                 done_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [BIN_WIDTH-1:0] bin_r;
   logic [BCD_W-1:0]     bcd_r;
   logic [BIN_WIDTH-1:0] sat_s;
   logic [BCD_W-1:0]     adj_s;

   function automatic bcd_t add3(input bcd_t d);
      return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
   endfunction

   // Clamp to the largest four-digit value
   always_comb begin
      if (32'(bin) > 32'd9999) begin
         sat_s = BIN_WIDTH'(32'd9999);
      end else begin
         sat_s = bin;
      end
   end

   // Add-3 correction on every BCD nibble before the shift
   always_comb begin
      adj_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         adj_s[4*i +: 4] = add3(bcd_r[4*i +: 4]);
      end
   end

   // Conversion state: load, iterate, flag completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         cnt_r  <= '0;
         bin_r  <= '0;
         bcd_r  <= '0;
      end else begin
         busy_r <= run_r;
         done_r <= 1'b0;
         if (start && ready) begin
            bin_r <= sat_s;
            bcd_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b1;
         end else if (run_r) begin
            {bcd_r, bin_r} <= {adj_s[BCD_W-2:0], bin_r, 1'b0};
            cnt_r          <= cnt_r + CNT_W'(1'b1);
            if (cnt_r == LAST_ITER) begin
               run_r  <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign ready = ~run_r & ~busy_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign bcd   = bcd_r;

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment driver fed by a sampled 10 kHz scan clock.
// Optional SEG_BLANK_LEADING_ZEROS_EN blanks digits above the most significant nonzero one.
module seven_seg_scanner #(
   parameter int BIN_WIDTH  = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scan_clk,
   input  logic [BIN_WIDTH-1:0] value,
   input  logic                 value_valid,
   output logic                 busy,
   output logic [3:0]           an,
   output logic [6:0]           seg,
   output logic                 dp
);

   import seg_pkg::*;

   logic [1:0]              sync_r;
   logic                    prev_r;
   logic                    tick_s;
   logic                    tick_d_r;
   logic [1:0]              idx_r;
   bcd_t [NUM_DIGITS-1:0]   disp_r;
   bcd_t [NUM_DIGITS-1:0]   conv_s;
   logic [BIN_WIDTH-1:0]    pend_r;
   logic                    pend_vld_r;
   logic [BIN_WIDTH-1:0]    start_val_s;
   logic                    start_s;
   logic                    ready_s;
   logic                    done_s;
   logic                    blank_s;
   logic [6:0]              seg_nxt_s;
   logic [3:0]              an_r;
   logic [6:0]              seg_r;

   assign tick_s  = sync_r[1] & ~prev_r;
   assign start_s = ready_s & (value_valid | pend_vld_r);

   // Scan clock synchronizer, edge detect and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r   <= 2'b00;
         prev_r   <= 1'b0;
         tick_d_r <= 1'b0;
         idx_r    <= 2'd3;
      end else begin
         sync_r   <= {sync_r[0], scan_clk};
         prev_r   <= sync_r[1];
         tick_d_r <= tick_s;
         if (tick_s) begin
            idx_r <= idx_r + 2'd1;
         end
      end
   end

   // A fresh strobe takes priority over a held pending value
   always_comb begin
      if (value_valid) begin
         start_val_s = value;
      end else begin
         start_val_s = pend_r;
      end
   end

   // Pending value (last write wins) and atomic display commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r     <= '0;
         pend_vld_r <= 1'b0;
         disp_r     <= '0;
      end else begin
         if (value_valid && !ready_s) begin
            pend_r     <= value;
            pend_vld_r <= 1'b1;
         end else if (start_s) begin
            pend_vld_r <= 1'b0;
         end
         if (done_s) begin
            disp_r <= conv_s;
         end
      end
   end

   bin2bcd_seq #(
      .BIN_WIDTH (BIN_WIDTH)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start_s),
      .bin   (start_val_s),
      .ready (ready_s),
      .busy  (busy),
      .done  (done_s),
      .bcd   (conv_s)
   );

`ifdef SEG_BLANK_LEADING_ZEROS_EN
   logic [1:0] msd_s;

   // Highest nonzero digit; value 0 keeps digit 0 lit
   always_comb begin
      msd_s = 2'd0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         msd_s = (disp_r[i] != 4'd0) ? 2'(i) : msd_s;
      end
      blank_s = (idx_r > msd_s);
   end
`else
   assign blank_s = 1'b0;
`endif

   // Segment pattern for the digit being scanned
   always_comb begin
      if (blank_s) begin
         seg_nxt_s = SEG_OFF;
      end else begin
         seg_nxt_s = seg_decode(disp_r[idx_r]);
      end
   end

   // Registered anode/segment drive, refreshed once per scan tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r  <= AN_OFF;
         seg_r <= SEG_OFF;
      end else if (tick_d_r) begin
         an_r  <= ~(NUM_DIGITS'(1'b1) << idx_r);
         seg_r <= seg_nxt_s;
      end
   end

   assign an  = an_r;
   assign seg = seg_r;
   assign dp  = 1'b1;

endmodule
